gnr_walk_ctrl: RTL and testbench
================================

// Module: gnr_walk_ctrl
// PURPOSE
//  Initiator that drives a bank of NUM_NODES no_rock-style network nodes.
//  For each initial state in a range it loads the nodes, then steps the slow
//  (s0, half-rate) and fast (s1, full-rate) trajectories until they collide,
//  which identifies an attractor. One result per initial state is returned on
//  a valid/ready port. Sits between the host/start logic and the node array.
// PARAMETERS
//  NUM_NODES  8     nodes in the network; width of state vectors
//  CNT_W      16    width of the step counter and res_steps
//  MAX_STEPS  4096  step budget per initial state before timeout (>=2)
// PORTS
//  clk          in   1          clock
//  rst          in   1          reset, synchronous, active-high
//  start        in   1          1-cycle pulse: begin a sweep (ignored unless IDLE)
//  init_first   in   NUM_NODES  first initial state (sampled on start)
//  init_last    in   NUM_NODES  last initial state (sampled on start)
//  busy         out  1          high from the accepted start until done
//  done         out  1          1-cycle pulse after the last result is accepted
//  reset_nos    out  1          to nodes: load init_state, re-arm s0 pass flag
//  init_state   out  NUM_NODES  to nodes: bit i = initial state of node i
//  start_s0     out  1          to nodes: step the slow trajectory
//  start_s1     out  1          to nodes: step the fast trajectory
//  rock_s0      in   NUM_NODES  from nodes: slow-trajectory state vector
//  rock_s1      in   NUM_NODES  from nodes: fast-trajectory state vector
//  res_valid    out  1          result available
//  res_ready    in   1          consumer accepts the result
//  res_init     out  NUM_NODES  initial state of this result
//  res_state    out  NUM_NODES  rock_s1 at collision/timeout
//  res_steps    out  CNT_W      steps taken at collision/timeout
//  res_timeout  out  1          1 = MAX_STEPS reached without collision
// BEHAVIOUR
//  Reset: state IDLE. busy, done, reset_nos, start_s0, start_s1 and res_valid
//   are 0. init_state, res_init, res_state, res_steps and res_timeout are 0.
//   Reset mid-sweep abandons the sweep. No result and no done pulse follow.
//  FSM: IDLE -> LOAD -> STEP <-> CMP -> OUT -> (LOAD | IDLE).
//  IDLE: start=1 latches init_first as cur and init_last as last. Go to LOAD.
//  LOAD (1 cycle): reset_nos=1 and init_state=cur. step_cnt<=0. Go to STEP.
//  STEP (1 cycle): start_s0=start_s1=1 and step_cnt<=step_cnt+1. Go to CMP.
//   The nodes update at this edge, so every step costs 2 cycles.
//  CMP: after k steps the nodes hold s0=f^ceil(k/2)(x) and s1=f^k(x).
//   If step_cnt>=2 and rock_s0==rock_s1: collision. Capture the result with
//    res_timeout=0. Go to OUT.
//   If step_cnt==1: no compare is made, because the first step always matches.
//   Else if step_cnt==MAX_STEPS: capture the result with res_timeout=1. Go to OUT.
//   Else go to STEP.
//   Collision takes priority over timeout in the same cycle.
//  Capture: res_init=cur, res_state=rock_s1, res_steps=step_cnt.
//  OUT: res_valid=1. Result fields stay stable until res_valid&&res_ready.
//   On acceptance: if cur==last, pulse done and go to IDLE. Otherwise
//   cur<=cur+1 (mod 2^NUM_NODES) and go to LOAD.
//   The range wraps, so init_first>init_last sweeps through all-ones to 0.
//   init_first==init_last gives exactly one result.
//  busy=1 in every state except IDLE. start while busy is ignored.
//  start_s0/start_s1/reset_nos are never asserted together.
//  The s0 half-rate stepping comes from the node pass flag, not from the
//   controller.
// TESTING
//  1 Identity net (rhoa=s), N=4, range 5..5 -> one result: init=5, state=5,
//    steps=2, timeout=0. Then a done pulse and busy low.
//  2 Toggle net (rhoa=~s), init 3 -> steps=4, state=4'h3, timeout=0.
//    Per-step rock_s0/rock_s1 trace matches f^ceil(k/2) and f^k.
//  3 4-bit counter net, MAX_STEPS=8 -> timeout=1, steps=8, state=init+8.
//    Then the next init loads.
//  4 Range 14..1 with N=4 -> results for 14, 15, 0, 1 in order, then done.
//  5 res_ready held low 20 cycles in OUT -> fields stable, no node pulses.
//    Extra start pulses are ignored.
//  6 rst asserted during STEP mid-sweep -> next cycle all outputs are 0 and
//    state is IDLE. A later start runs cleanly from init_first.

Source files
------------

// File: rtl/gnr_walk_ctrl.sv
// ============================================================================
//  Module      : gnr_walk_ctrl
//  Description : Sweeps a range of initial states through a node array and
//                detects attractors by slow/fast trajectory collision.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gnr_walk_ctrl #(
  parameter int NUM_NODES = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_NODES-1:0] init_first,
  input  logic [NUM_NODES-1:0] init_last,
  output logic                 busy,
  output logic                 done,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  input  logic [NUM_NODES-1:0] rock_s0,
  input  logic [NUM_NODES-1:0] rock_s1,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NUM_NODES-1:0] res_init,
  output logic [NUM_NODES-1:0] res_state,
  output logic [CNT_W-1:0]     res_steps,
  output logic                 res_timeout
);

  localparam logic [CNT_W-1:0] c_max_steps = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_two       = CNT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_STEP = 3'd2,
    S_CMP  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t               r_state;
  logic [NUM_NODES-1:0] r_cur;
  logic [NUM_NODES-1:0] r_last;
  logic [CNT_W-1:0]     r_step_cnt;

  logic                 w_collide;
  logic                 w_timeout;
  logic                 w_last_init;
  logic [NUM_NODES-1:0] w_next_cur;

  // The first step always leaves both trajectories equal, so it is never compared.
  assign w_collide   = (r_step_cnt >= c_two) && (rock_s0 == rock_s1);
  assign w_timeout   = (r_step_cnt != c_one) && (r_step_cnt == c_max_steps);
  assign w_last_init = (r_cur == r_last);
  assign w_next_cur  = r_cur + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_last      <= '0;
      r_step_cnt  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      reset_nos   <= 1'b0;
      init_state  <= '0;
      start_s0    <= 1'b0;
      start_s1    <= 1'b0;
      res_valid   <= 1'b0;
      res_init    <= '0;
      res_state   <= '0;
      res_steps   <= '0;
      res_timeout <= 1'b0;
    end else begin
      done      <= 1'b0;
      reset_nos <= 1'b0;
      start_s0  <= 1'b0;
      start_s1  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur      <= init_first;
            r_last     <= init_last;
            init_state <= init_first;
            reset_nos  <= 1'b1;
            busy       <= 1'b1;
            r_state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_step_cnt <= '0;
          start_s0   <= 1'b1;
          start_s1   <= 1'b1;
          r_state    <= S_STEP;
        end

        S_STEP: begin
          r_step_cnt <= r_step_cnt + c_one;
          r_state    <= S_CMP;
        end

        S_CMP: begin
          if (w_collide || w_timeout) begin
            res_init    <= r_cur;
            res_state   <= rock_s1;
            res_steps   <= r_step_cnt;
            res_timeout <= ~w_collide;
            res_valid   <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            start_s0 <= 1'b1;
            start_s1 <= 1'b1;
            r_state  <= S_STEP;
          end
        end

        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (w_last_init) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cur      <= w_next_cur;
              init_state <= w_next_cur;
              reset_nos  <= 1'b1;
              r_state    <= S_LOAD;
            end
          end
        end

        default: begin
          busy      <= 1'b0;
          res_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gnr_walk_ctrl.sv
// ============================================================================
//  Module      : tb_gnr_walk_ctrl
//  Description : Self-checking bench for gnr_walk_ctrl with a behavioural
//                node array and a closed-form attractor model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gnr_walk_ctrl;

  localparam int N     = 4;
  localparam int CW    = 16;
  localparam int MAXS  = 8;

  localparam int NET_ID  = 0;
  localparam int NET_TOG = 1;
  localparam int NET_CNT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  init_first = '0;
  logic [N-1:0]  init_last = '0;
  logic          busy, done, reset_nos, start_s0, start_s1;
  logic [N-1:0]  init_state;
  logic [N-1:0]  rock_s0 = '0;
  logic [N-1:0]  rock_s1 = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [N-1:0]  res_init, res_state;
  logic [CW-1:0] res_steps;
  logic          res_timeout;

  logic [N-1:0]  lut [16];
  logic          pass_flag = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  gnr_walk_ctrl #(.NUM_NODES(N), .CNT_W(CW), .MAX_STEPS(MAXS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .init_first(init_first), .init_last(init_last),
    .busy(busy), .done(done), .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1),
    .rock_s0(rock_s0), .rock_s1(rock_s1),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_init(res_init), .res_state(res_state),
    .res_steps(res_steps), .res_timeout(res_timeout)
  );

  // Node array: s0 advances only on every other start_s0 (pass flag).
  always @(posedge clk) begin
    if (reset_nos) begin
      rock_s0   <= init_state;
      rock_s1   <= init_state;
      pass_flag <= 1'b0;
    end else begin
      if (start_s1) rock_s1 <= lut[rock_s1];
      if (start_s0) begin
        if (!pass_flag) rock_s0 <= lut[rock_s0];
        pass_flag <= ~pass_flag;
      end
    end
  end

  typedef struct {
    int           net;
    logic [N-1:0] init;
    logic [N-1:0] e_state;
    int           e_steps;
    logic         e_to;
  } vec_t;

  task automatic set_net(input int net);
    for (int i = 0; i < 16; i++) begin
      case (net)
        NET_ID:  lut[i] = N'(i);
        NET_TOG: lut[i] = ~N'(i);
        NET_CNT: lut[i] = N'(i + 1);
        default: lut[i] = N'($urandom_range(0, 15));
      endcase
    end
  endtask

  function automatic logic [N-1:0] fpow(input logic [N-1:0] x, input int k);
    logic [N-1:0] v = x;
    for (int i = 0; i < k; i++) v = lut[v];
    return v;
  endfunction

  task automatic model(input logic [N-1:0] x, output logic [N-1:0] st,
                       output int steps, output logic to);
    st = fpow(x, MAXS); steps = MAXS; to = 1'b1;
    for (int k = MAXS; k >= 2; k--) begin
      if (fpow(x, (k + 1) / 2) == fpow(x, k)) begin
        st = fpow(x, k); steps = k; to = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset_nos) pulses = 0;
    if (start_s1) pulses++;
    chk("node_pulse_exclusive",
        32'((reset_nos && (start_s0 || start_s1)) || (start_s0 != start_s1)), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_nodes"}, 32'({reset_nos, start_s0, start_s1}), 0);
    chk({tag, "_valid"}, 32'(res_valid), 0);
    chk({tag, "_fields"}, 32'({init_state, res_init, res_state, res_timeout}), 0);
    chk({tag, "_steps"}, 32'(res_steps), 0);
  endtask

  task automatic pulse_start(input logic [N-1:0] first, input logic [N-1:0] last);
    init_first = first;
    init_last  = last;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_load", 32'({reset_nos, init_state}), 32'({1'b1, first}));
  endtask

  task automatic get_result(input logic [N-1:0] e_init, input logic [N-1:0] e_state,
                            input int e_steps, input logic e_to,
                            input int hold, input bit is_last);
    int n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    chk("result_wait", 32'(res_valid), 1);
    if (!res_valid) return;
    chk("res_init", 32'(res_init), 32'(e_init));
    chk("res_state", 32'(res_state), 32'(e_state));
    chk("res_steps", 32'(res_steps), 32'(e_steps));
    chk("res_timeout", 32'(res_timeout), 32'(e_to));
    chk("step_pulses", 32'(pulses), 32'(e_steps));
    for (int i = 0; i < hold; i++) begin
      start = (i % 2 == 0);
      tick();
      chk("hold_fields", 32'({res_valid, res_init, res_state, res_steps, res_timeout}),
          32'({1'b1, e_init, e_state, 16'(e_steps), e_to}));
      chk("hold_quiet", 32'({reset_nos, start_s1, done}), 0);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("accept_valid", 32'(res_valid), 0);
    if (is_last) begin
      chk("done_pulse", 32'({done, busy}), 32'(2'b10));
      tick();
      chk("done_clear", 32'(done), 0);
    end else begin
      chk("next_load", 32'({done, busy, reset_nos, init_state}),
          32'({1'b0, 1'b1, 1'b1, N'(e_init + 1)}));
    end
  endtask

  task automatic run_sweep(input logic [N-1:0] first, input logic [N-1:0] last,
                           input int hold);
    logic [N-1:0] cur = first;
    logic [N-1:0] st;
    int           steps;
    logic         to;
    pulse_start(first, last);
    for (int i = 0; i < 17; i++) begin
      model(cur, st, steps, to);
      get_result(cur, st, steps, to, hold, cur == last);
      if (cur == last) break;
      cur = cur + 1'b1;
    end
  endtask

  initial begin
    vec_t vt[5];
    int   n;
    logic [N-1:0] f;
    vt[0] = '{NET_ID,  4'h5, 4'h5, 2, 1'b0};
    vt[1] = '{NET_TOG, 4'h3, 4'h3, 4, 1'b0};
    vt[2] = '{NET_CNT, 4'h7, 4'hF, 8, 1'b1};
    vt[3] = '{NET_TOG, 4'hA, 4'hA, 4, 1'b0};
    vt[4] = '{NET_CNT, 4'hC, 4'h4, 8, 1'b1};

    set_net(NET_ID);
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("idle");

    // Single-result vectors with hand-derived expectations.
    for (int i = 0; i < 5; i++) begin
      set_net(vt[i].net);
      pulse_start(vt[i].init, vt[i].init);
      get_result(vt[i].init, vt[i].e_state, vt[i].e_steps, vt[i].e_to, 0, 1'b1);
    end

    // Counter net timeout followed by the next init loading.
    set_net(NET_CNT);
    pulse_start(4'h2, 4'h3);
    get_result(4'h2, 4'hA, 8, 1'b1, 1, 1'b0);
    get_result(4'h3, 4'hB, 8, 1'b1, 0, 1'b1);

    // Wrapping range 14..1.
    set_net(NET_ID);
    pulse_start(4'hE, 4'h1);
    get_result(4'hE, 4'hE, 2, 1'b0, 0, 1'b0);
    get_result(4'hF, 4'hF, 2, 1'b0, 0, 1'b0);
    get_result(4'h0, 4'h0, 2, 1'b0, 0, 1'b0);
    get_result(4'h1, 4'h1, 2, 1'b0, 0, 1'b1);

    // Consumer stalls 20 cycles with stray start pulses.
    set_net(NET_TOG);
    pulse_start(4'h6, 4'h6);
    get_result(4'h6, 4'h6, 4, 1'b0, 20, 1'b1);

    // Reset in STEP mid-sweep, then a clean restart.
    set_net(NET_CNT);
    pulse_start(4'h0, 4'h3);
    n = 0;
    while (n < 2 && pulses < 40) begin
      tick();
      if (start_s1) n++;
    end
    chk("reached_step", 32'(start_s1), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midrst");
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("post_rst_quiet", 32'({busy, done, res_valid, reset_nos, start_s1}), 0);
    end
    set_net(NET_ID);
    run_sweep(4'h9, 4'hA, 0);

    // Randomised networks and ranges against the reference model.
    for (int r = 0; r < 25; r++) begin
      set_net(3);
      f = N'($urandom_range(0, 15));
      run_sweep(f, N'(f + $urandom_range(0, 3)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
